// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// reset value and default table geometry.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] CTR_RESET     = WNT;
  localparam int         DEF_ENTRY_BIT = 5;
  localparam int         DEF_PHT_BIT   = 6;
  localparam int         DEF_GHR_BIT   = 6;

  // Saturating step of a 2-bit counter toward taken / not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : c + 2'd1;
    end
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pattern_table.sv
// Pattern history table: one 2-bit saturating counter per index, combinational
// read of the taken bit, single saturating update per clock.
module bp_pattern_table
  import bp_pkg::*;
#(
  parameter int PHT_BIT = DEF_PHT_BIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHT_BIT-1:0] rd_idx,
  output logic               rd_taken,
  input  logic               wr_en,
  input  logic [PHT_BIT-1:0] wr_idx,
  input  logic               wr_taken
);

  localparam int N = 1 << PHT_BIT;

  logic [N-1:0][1:0] pht_q;
  logic [N-1:0][1:0] pht_d;

  always_comb begin
    pht_d = pht_q;
    if (wr_en) begin
      pht_d[wr_idx] = ctr_next(pht_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pht_q <= {N{CTR_RESET}};
    end else begin
      pht_q <= pht_d;
    end
  end

  assign rd_taken = pht_q[rd_idx][1];

endmodule

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB plus gshare/bimodal PHT, with
// EX-stage resolution that raises is_flush and steers next_pc on mispredict.
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRY_BIT  = DEF_ENTRY_BIT,
  parameter int PHT_BIT    = DEF_PHT_BIT,
  parameter int GHR_BIT    = DEF_GHR_BIT,
  parameter int USE_GSHARE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        current_pc,
  input  logic [31:0]        IF_ID_pc,
  input  logic [31:0]        ID_EX_pc,
  input  logic               ID_EX_valid,
  input  logic               ID_EX_is_branch,
  input  logic               ID_EX_is_jal,
  input  logic               ID_EX_is_jalr,
  input  logic               EX_alu_bcond,
  input  logic [31:0]        EX_pc_plus_imm,
  input  logic [31:0]        EX_alu_result,
  input  logic [PHT_BIT-1:0] ID_EX_pht_idx,
  output logic [PHT_BIT-1:0] pred_pht_idx,
  output logic               is_flush,
  output logic [31:0]        next_pc
);

  localparam int ENTRIES = 1 << ENTRY_BIT;
  localparam int TAG_W   = 30 - ENTRY_BIT;

  logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [ENTRIES-1:0] btb_is_br_q, btb_is_br_d;
  logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
  logic [31:0]        btb_target_q [ENTRIES];
  logic [GHR_BIT-1:0] ghr_q, ghr_d, ghr_shift;

  logic [ENTRY_BIT-1:0] fetch_idx, ex_idx;
  logic [PHT_BIT-1:0]   ghr_ext;
  logic                 fetch_hit, pred_taken;
  logic                 ex_ctrl, br_upd;
  logic [31:0]          res_target, wr_target;

  assign fetch_idx = current_pc[ENTRY_BIT+1:2];
  assign ex_idx    = ID_EX_pc[ENTRY_BIT+1:2];
  assign fetch_hit = btb_valid_q[fetch_idx] &&
                     (btb_tag_q[fetch_idx] == current_pc[31:ENTRY_BIT+2]);
  assign ex_ctrl   = ID_EX_valid && (ID_EX_is_branch || ID_EX_is_jal || ID_EX_is_jalr);
  assign br_upd    = ID_EX_valid && ID_EX_is_branch;
  assign wr_target = ID_EX_is_jalr ? EX_alu_result : EX_pc_plus_imm;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BIT-1:0] = ghr_q;
    pred_pht_idx = current_pc[PHT_BIT+1:2] ^ ((USE_GSHARE != 0) ? ghr_ext : '0);
  end

  bp_pattern_table #(.PHT_BIT(PHT_BIT)) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_pht_idx),
    .rd_taken (pred_taken),
    .wr_en    (br_upd),
    .wr_idx   (ID_EX_pht_idx),
    .wr_taken (EX_alu_bcond)
  );

  // Resolved path of the EX instruction; not-taken branches fall through.
  always_comb begin
    res_target = ID_EX_pc + 32'd4;
    if (ID_EX_is_jal) begin
      res_target = EX_pc_plus_imm;
    end else if (ID_EX_is_jalr) begin
      res_target = EX_alu_result;
    end else if (ID_EX_is_branch && EX_alu_bcond) begin
      res_target = EX_pc_plus_imm;
    end
    is_flush = ex_ctrl && (IF_ID_pc != res_target);
    if (is_flush) begin
      next_pc = res_target;
    end else if (fetch_hit && (!btb_is_br_q[fetch_idx] || pred_taken)) begin
      next_pc = btb_target_q[fetch_idx];
    end else begin
      next_pc = current_pc + 32'd4;
    end
  end

  generate
    if (GHR_BIT == 1) begin : g_ghr_one
      assign ghr_shift = EX_alu_bcond;
    end else begin : g_ghr_many
      assign ghr_shift = {ghr_q[GHR_BIT-2:0], EX_alu_bcond};
    end
  endgenerate

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_is_br_d = btb_is_br_q;
    ghr_d       = br_upd ? ghr_shift : ghr_q;
    if (ex_ctrl) begin
      btb_valid_d[ex_idx] = 1'b1;
      btb_is_br_d[ex_idx] = ID_EX_is_branch;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btb_valid_q <= '0;
      btb_is_br_q <= '0;
      ghr_q       <= '0;
    end else begin
      btb_valid_q <= btb_valid_d;
      btb_is_br_q <= btb_is_br_d;
      ghr_q       <= ghr_d;
    end
  end

  // Tag/target payload needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (ex_ctrl) begin
      btb_tag_q[ex_idx]    <= ID_EX_pc[31:ENTRY_BIT+2];
      btb_target_q[ex_idx] <= wr_target;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomised and directed bench for gshare_branch_predictor against a
// behavioural model of BTB, counters and global history.
module tb_gshare_branch_predictor;

  localparam int EB = 5;
  localparam int PB = 6;
  localparam int GB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc, IF_ID_pc, ID_EX_pc, EX_pc_plus_imm, EX_alu_result;
  logic        ID_EX_valid, ID_EX_is_branch, ID_EX_is_jal, ID_EX_is_jalr, EX_alu_bcond;
  logic [PB-1:0] ID_EX_pht_idx, pred_pht_idx;
  logic        is_flush;
  logic [31:0] next_pc;

  gshare_branch_predictor #(.ENTRY_BIT(EB), .PHT_BIT(PB), .GHR_BIT(GB), .USE_GSHARE(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .current_pc      (current_pc),
    .IF_ID_pc        (IF_ID_pc),
    .ID_EX_pc        (ID_EX_pc),
    .ID_EX_valid     (ID_EX_valid),
    .ID_EX_is_branch (ID_EX_is_branch),
    .ID_EX_is_jal    (ID_EX_is_jal),
    .ID_EX_is_jalr   (ID_EX_is_jalr),
    .EX_alu_bcond    (EX_alu_bcond),
    .EX_pc_plus_imm  (EX_pc_plus_imm),
    .EX_alu_result   (EX_alu_result),
    .ID_EX_pht_idx   (ID_EX_pht_idx),
    .pred_pht_idx    (pred_pht_idx),
    .is_flush        (is_flush),
    .next_pc         (next_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  bit          m_valid [32];
  bit          m_br    [32];
  int unsigned m_tag   [32];
  logic [31:0] m_tgt   [32];
  int          m_pht   [64];
  int          m_ghr;

  int checks = 0;
  int errors = 0;
  logic [31:0] obs_next;
  logic        obs_flush;
  logic [PB-1:0] obs_idx;

  logic [31:0] pool [8] = '{32'h40, 32'h44, 32'h90, 32'h100, 32'h140, 32'h1040, 32'h2090, 32'h3c};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_br[i]    = 0;
    end
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr = 0;
  endfunction

  function automatic int m_fetch_idx(input logic [31:0] pc);
    return (int'((pc >> 2) % 64)) ^ m_ghr;
  endfunction

  function automatic logic [31:0] m_res_target();
    if (ID_EX_is_jal) return EX_pc_plus_imm;
    if (ID_EX_is_jalr) return EX_alu_result;
    if (ID_EX_is_branch && EX_alu_bcond) return EX_pc_plus_imm;
    return ID_EX_pc + 4;
  endfunction

  task automatic set_ex(input bit v, input bit br, input bit jal, input bit jalr, input bit bc,
                        input logic [31:0] idpc, input logic [31:0] ifid,
                        input logic [31:0] imm, input logic [31:0] alu, input int pidx);
    ID_EX_valid = v; ID_EX_is_branch = br; ID_EX_is_jal = jal; ID_EX_is_jalr = jalr;
    EX_alu_bcond = bc; ID_EX_pc = idpc; IF_ID_pc = ifid;
    EX_pc_plus_imm = imm; EX_alu_result = alu; ID_EX_pht_idx = PB'(pidx);
  endtask

  // One transaction: sample at negedge, compare to model, then advance the model.
  task automatic step(input string tag);
    int e, ei, exp_idx;
    bit ctrl, hit, pt, exp_flush;
    logic [31:0] rt, exp_next;
    @(negedge clk);
    obs_next = next_pc; obs_flush = is_flush; obs_idx = pred_pht_idx;
    exp_idx   = m_fetch_idx(current_pc);
    ctrl      = ID_EX_valid && (ID_EX_is_branch || ID_EX_is_jal || ID_EX_is_jalr);
    rt        = m_res_target();
    exp_flush = ctrl && (IF_ID_pc != rt);
    e         = int'((current_pc >> 2) % 32);
    hit       = m_valid[e] && (m_tag[e] == (current_pc >> 7));
    pt        = hit && (!m_br[e] || m_pht[exp_idx] >= 2);
    exp_next  = exp_flush ? rt : (pt ? m_tgt[e] : current_pc + 4);
    $display("%s pc=%h next=%h flush=%0d idx=%h", tag, current_pc, next_pc, is_flush, pred_pht_idx);
    check_val({tag, ".idx"}, 32'(pred_pht_idx), exp_idx);
    check_val({tag, ".flush"}, 32'(is_flush), 32'(exp_flush));
    check_val({tag, ".next"}, next_pc, exp_next);
    if (ctrl) begin
      ei = int'((ID_EX_pc >> 2) % 32);
      m_valid[ei] = 1;
      m_tag[ei]   = ID_EX_pc >> 7;
      m_tgt[ei]   = ID_EX_is_jalr ? EX_alu_result : EX_pc_plus_imm;
      m_br[ei]    = ID_EX_is_branch;
      if (ID_EX_is_branch) begin
        if (EX_alu_bcond) begin
          if (m_pht[ID_EX_pht_idx] < 3) m_pht[ID_EX_pht_idx]++;
        end else begin
          if (m_pht[ID_EX_pht_idx] > 0) m_pht[ID_EX_pht_idx]--;
        end
        m_ghr = ((m_ghr << 1) | int'(EX_alu_bcond)) % 16;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cls;
    logic [31:0] good;
    reset = 1'b0;
    current_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    step("reset");
    check_val("reset.next_lit", obs_next, 32'h104);
    check_val("reset.flush_lit", 32'(obs_flush), 0);
    check_val("reset.idx_lit", 32'(obs_idx), 0);

    // jal mispredict then BTB hit
    set_ex(1, 0, 1, 0, 0, 32'h100, 32'h104, 32'h200, 0, 0);
    step("jal");
    check_val("jal.flush_lit", 32'(obs_flush), 1);
    check_val("jal.next_lit", obs_next, 32'h200);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("jal_hit");
    check_val("jal_hit.next_lit", obs_next, 32'h200);
    check_val("jal_hit.idx_lit", 32'(obs_idx), 0);

    // Branch at 0x40 with outcomes T,T,N,T
    for (int k = 0; k < 4; k++) begin
      current_pc = 32'h40;
      set_ex(1, 1, 0, 0, (k != 2), 32'h40, 32'h44, 32'h80, 0, m_fetch_idx(32'h40));
      step("br40");
      if (k == 0) begin
        check_val("br40.flush_lit", 32'(obs_flush), 1);
        check_val("br40.next_lit", obs_next, 32'h80);
      end
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    current_pc = 32'h40;
    step("ghr");
    check_val("ghr.idx_lit", 32'(obs_idx), 32'h1d);

    // Saturation on index 0x2A: five taken, one not-taken
    for (int k = 0; k < 6; k++) begin
      set_ex(1, 1, 0, 0, (k != 5), 32'h90, 32'h94, 32'h500, 0, 32'h2a);
      step("sat");
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    current_pc = 32'h90;
    step("sat_pred");
    check_val("sat.idx_lit", 32'(obs_idx), 32'h2a);
    check_val("sat.next_lit", obs_next, 32'h500);

    // Bubble carrying a jal class bit must not flush or write the BTB
    current_pc = 32'h700;
    set_ex(0, 0, 1, 0, 0, 32'h700, 32'h123, 32'h900, 0, 0);
    step("bubble");
    check_val("bubble.flush_lit", 32'(obs_flush), 0);
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("bubble_fetch");
    check_val("bubble.next_lit", obs_next, 32'h704);

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      current_pc = pool[$urandom % 8];
      cls = $urandom % 5;
      set_ex(($urandom % 4) != 0, (cls == 1 || cls == 4), (cls == 2), (cls == 3),
             $urandom % 2, pool[$urandom % 8], 0, pool[$urandom % 8], pool[$urandom % 8],
             ($urandom % 2) ? int'($urandom % 64) : 0);
      if (($urandom % 2) != 0) ID_EX_pht_idx = PB'(m_fetch_idx(ID_EX_pc));
      good = m_res_target();
      case ($urandom % 3)
        0: IF_ID_pc = good;
        1: IF_ID_pc = ID_EX_pc + 4;
        default: IF_ID_pc = pool[$urandom % 8];
      endcase
      step("rand");
    end

    // Mid-stream reset drops the pending update and clears the BTB
    current_pc = 32'h100;
    set_ex(1, 0, 1, 0, 0, 32'h100, 32'h104, 32'h200, 0, 0);
    step("pre_rst");
    set_ex(1, 0, 1, 0, 0, 32'h140, 32'h144, 32'h300, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    current_pc = 32'h100;
    step("post_rst");
    check_val("post_rst.next_lit", obs_next, 32'h104);
    current_pc = 32'h140;
    step("post_rst2");
    check_val("post_rst2.next_lit", obs_next, 32'h144);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
